// File: rtl/gpio_unit.sv
// Memory-mapped GPIO at data address 31: synchronized inputs, sticky rising-edge
// flags, output pin register. Define GPIO_DEBOUNCE_EN to add per-pin debounce.
module gpio_unit #(
  parameter int          N_IN            = 8,
  parameter int          N_OUT           = 8,
  parameter logic [7:0]  OUT_RESET       = 8'h00,
  parameter int          DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        uop,
  input  logic [31:0]       addr,
  input  logic [31:0]       wr_data,
  input  logic [N_IN-1:0]   pins_in,
  output logic [N_OUT-1:0]  pins_out,
  output logic [31:0]       gpio_state
);

  localparam logic [4:0]  UOP_LDR   = 5'd10;
  localparam logic [4:0]  UOP_STR   = 5'd11;
  localparam logic [31:0] GPIO_ADDR = 32'd31;

  logic              sel, rd, wr;
  logic [N_IN-1:0]   s1_q, s2_q;
  logic [N_IN-1:0]   in_state_q, in_state_d;
  logic [N_IN-1:0]   rise_q, rise_d;
  logic [N_OUT-1:0]  pins_out_q, pins_out_d;

  assign sel = (addr == GPIO_ADDR);
  assign rd  = (uop == UOP_LDR) & sel;
  assign wr  = (uop == UOP_STR) & sel;

`ifdef GPIO_DEBOUNCE_EN
  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_IN-1:0][CW-1:0] cnt_q, cnt_d;

  // A pin is accepted only after it disagrees with in_state for DEBOUNCE_CYCLES edges in a row.
  always_comb begin
    in_state_d = in_state_q;
    cnt_d      = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (s2_q[i] != in_state_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          in_state_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign in_state_d = s2_q;
`endif

  // Set beats the read-clear when both land on the same edge.
  assign rise_d     = (rd ? '0 : rise_q) | (in_state_d & ~in_state_q);
  assign pins_out_d = wr ? wr_data[N_OUT-1:0] : pins_out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      in_state_q <= '0;
      rise_q     <= '0;
      pins_out_q <= OUT_RESET[N_OUT-1:0];
    end else begin
      s1_q       <= pins_in;
      s2_q       <= s1_q;
      in_state_q <= in_state_d;
      rise_q     <= rise_d;
      pins_out_q <= pins_out_d;
    end
  end

  assign pins_out   = pins_out_q;
  assign gpio_state = {8'd0, 8'(rise_q), 8'(pins_out_q), 8'(in_state_q)};

  logic unused_cfg;
  assign unused_cfg = ^{wr_data[31:N_OUT], 32'(DEBOUNCE_CYCLES)};

endmodule

// File: tb/tb_gpio_unit.sv
// Scoreboard bench for gpio_unit: stimulus queues expected words tagged with the
// cycle they are due; a negedge monitor pops and compares them.
module tb_gpio_unit;

  localparam int DB = 4;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = 2 + DB;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  uop;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [7:0]  pins_in;
  logic [7:0]  pins_out;
  logic [31:0] gpio_state;

  gpio_unit #(
    .N_IN(8), .N_OUT(8), .OUT_RESET(8'hA5), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk), .rst(rst), .uop(uop), .addr(addr), .wr_data(wr_data),
    .pins_in(pins_in), .pins_out(pins_out), .gpio_state(gpio_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          is_po;
    logic [31:0] exp;
    logic [31:0] mask;
    string       name;
  } item_t;

  item_t sb[$];
  int    cyc    = 0;
  int    n_run  = 0;
  int    n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [31:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        act = sb[i].is_po ? {24'd0, pins_out} : gpio_state;
        n_run++;
        if (sb[i].cyc < cyc || (act & sb[i].mask) !== (sb[i].exp & sb[i].mask)) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h (mask %h)",
                   sb[i].name, act, sb[i].exp, sb[i].mask);
        end
        sb.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_gs(input int d, input logic [31:0] e, input logic [31:0] m,
                           input string nm);
    item_t it;
    it.cyc = cyc + d; it.is_po = 1'b0; it.exp = e; it.mask = m; it.name = nm;
    sb.push_back(it);
  endtask

  task automatic expect_po(input int d, input logic [7:0] e, input string nm);
    item_t it;
    it.cyc = cyc + d; it.is_po = 1'b1; it.exp = {24'd0, e}; it.mask = 32'hFF; it.name = nm;
    sb.push_back(it);
  endtask

  task automatic access(input logic [4:0] u, input logic [31:0] a, input logic [31:0] d);
    uop = u; addr = a; wr_data = d;
  endtask

  initial begin
    rst = 1'b1; pins_in = 8'h00;
    access(5'd0, 32'd0, 32'd0);
    tick(); tick();
    rst = 1'b0;
    expect_gs(0, 32'h0000A500, '1, "reset_gs");
    expect_po(0, 8'hA5, "reset_po");
    n_run++;
    if (pins_out !== 8'hA5) begin
      n_fail++;
      $display("FAIL direct_reset_po: got %h expected a5", pins_out);
    end
    n_run++;
    if (gpio_state !== 32'h0000A500) begin
      n_fail++;
      $display("FAIL direct_reset_gs: got %h expected 0000a500", gpio_state);
    end

    access(5'd11, 32'd31, 32'h1234_5678);
    expect_po(0, 8'hA5, "str_same_cycle");
    tick();
    access(5'd0, 32'd0, 32'd0);
    expect_po(0, 8'h78, "str_write");
    expect_gs(0, 32'h00007800, '1, "str_gs");
    n_run++;
    if (pins_out !== 8'h78) begin
      n_fail++;
      $display("FAIL direct_str_write: got %h expected 78", pins_out);
    end

    access(5'd11, 32'd30, 32'h0000_00FF);
    tick();
    access(5'd0, 32'd0, 32'd0);
    expect_po(0, 8'h78, "str_addr30");
    n_run++;
    if (pins_out !== 8'h78) begin
      n_fail++;
      $display("FAIL direct_str_addr30: got %h expected 78", pins_out);
    end

    access(5'd10, 32'd31, 32'h0000_00AA);
    tick();
    access(5'd0, 32'd0, 32'd0);
    expect_po(0, 8'h78, "ldr_no_write");

    access(5'd11, 32'd31, 32'h0000_003C);
    tick();
    access(5'd10, 32'd31, 32'd0);
    expect_gs(0, 32'h00003C00, '1, "str_then_ldr");
    tick();
    access(5'd0, 32'd0, 32'd0);

    pins_in = 8'h01;
    expect_gs(LAT - 1, 32'h00003C00, '1, "in_not_yet");
    expect_gs(LAT, 32'h00013C01, '1, "in_rise");
    repeat (LAT) tick();
    access(5'd10, 32'd31, 32'd0);
    expect_gs(0, 32'h00013C01, '1, "ldr_pre_clear");
    tick();
    access(5'd0, 32'd0, 32'd0);
    expect_gs(0, 32'h00003C01, '1, "rise_cleared");
    n_run++;
    if (gpio_state !== 32'h00003C01) begin
      n_fail++;
      $display("FAIL direct_rise_cleared: got %h expected 00003c01", gpio_state);
    end

    pins_in = 8'h00;
    expect_gs(LAT, 32'h00003C00, '1, "in_fall_no_rise");
    repeat (LAT) tick();
    pins_in = 8'h01;
    tick();
    pins_in = 8'h05;
    repeat (LAT - 1) tick();
    access(5'd10, 32'd31, 32'd0);
    expect_gs(0, 32'h00013C01, '1, "ldr_bit0");
    tick();
    expect_gs(0, 32'h00043C05, '1, "collision_set_wins");
    tick();
    access(5'd0, 32'd0, 32'd0);
    expect_gs(0, 32'h00003C05, '1, "b2b_ldr_clear");

    rst = 1'b1;
    access(5'd11, 32'd31, 32'h0000_0055);
    tick();
    rst = 1'b0;
    access(5'd0, 32'd0, 32'd0);
    expect_po(0, 8'hA5, "reset_beats_wr");
    expect_gs(0, 32'h0000A500, '1, "reset_mid_gs");
    n_run++;
    if (pins_out !== 8'hA5) begin
      n_fail++;
      $display("FAIL direct_reset_beats_wr: got %h expected a5", pins_out);
    end
    expect_gs(LAT - 1, 32'h0000A500, '1, "post_reset_wait");
    expect_gs(LAT, 32'h0005A505, '1, "post_reset_in");
    repeat (LAT) tick();

`ifdef GPIO_DEBOUNCE_EN
    pins_in = 8'h07;
    for (int d = 1; d <= 12; d++) expect_gs(d, 32'h0, 32'h00020002, "glitch_blocked");
    repeat (3) tick();
    pins_in = 8'h05;
    repeat (10) tick();

    pins_in = 8'h07;
    expect_gs(LAT - 1, 32'h0, 32'h00020002, "db_not_yet");
    expect_gs(LAT, 32'h00020002, 32'h00020002, "db_accept");
    repeat (10) tick();

    pins_in = 8'h0F;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_gs(LAT - 1, 32'h0, 32'h00000008, "db_reset_restart");
    expect_gs(LAT, 32'h00000008, 32'h00000008, "db_reset_accept");
    repeat (LAT) tick();
`endif

    for (int k = 0; k < 40 && sb.size() > 0; k++) tick();
    while (sb.size() > 0) begin
      n_run++;
      n_fail++;
      $display("FAIL %s: never checked, expected %h", sb[0].name, sb[0].exp);
      void'(sb.pop_front());
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
